entry_sequencer: RTL and testbench
==================================

Name: entry_sequencer

Overview:
Control unit that sequences the entry/accumulate/display datapath from the front-panel enter button. It synchronizes and debounces the raw active-low nenter button and issues one load strobe per press. It counts a fixed number of accepted entries, then starts the datapath computation and holds the result on display until the next press restarts the cycle. Sits beside the datapath unit in the top level and replaces direct button-to-datapath wiring.

Parameters:
NUM_ENTRIES, 4, number of accepted entries before computation starts (2..15)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to change the debounced level (>=2)
TIMEOUT_CYCLES, 64, idle cycles allowed between entries; used only with ENTRY_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
nenter  in  1  raw enter button, active-low, asynchronous to clk
inputdata_ready  in  1  datapath acknowledge: load captured
compute_done  in  1  datapath computation finished (level or pulse)
loaddata  out  1  one-cycle strobe: datapath captures inputdata
clear_acc  out  1  one-cycle strobe: datapath clears its accumulator and registers
compute_start  out  1  one-cycle strobe: datapath begins computation
show_result  out  1  high while the result is displayed
entry_count  out  4  accepted entries in the current cycle
state_code  out  3  current FSM state encoding, for debug or display
err_timeout  out  1  sticky entry-timeout flag

Behaviour:
- Reset (nreset low, asynchronous): FSM=CLEAR; all strobes 0; show_result=0; entry_count=0; err_timeout=0; synchronizer and debounce state indicate released.
- Input path: 2-FF synchronizer on nenter, then debouncer. The debounced level toggles only after DEBOUNCE_CYCLES consecutive equal samples differing from the current level.
- press_evt: one-cycle pulse on the released->pressed transition of the debounced level. Holding the button produces exactly one event. Glitches shorter than DEBOUNCE_CYCLES produce none.
- Latency: loaddata rises 2+DEBOUNCE_CYCLES+1 clk edges after the first edge that samples nenter low (7 with defaults), provided the FSM is in WAIT_ENTRY.
- State codes: CLEAR=0, WAIT_ENTRY=1, LOAD=2, WAIT_ACK=3, COMPUTE=4, WAIT_DONE=5, SHOW=6.
- CLEAR: clear_acc=1 for one cycle, entry_count<=0 -> WAIT_ENTRY.
- WAIT_ENTRY: on press_evt -> LOAD.
- LOAD: loaddata=1 for exactly one cycle; entry_count<=entry_count+1 -> WAIT_ACK.
- WAIT_ACK: wait for inputdata_ready=1. Then, if entry_count==NUM_ENTRIES -> COMPUTE, else -> WAIT_ENTRY.
- COMPUTE: compute_start=1 for one cycle -> WAIT_DONE.
- WAIT_DONE: on compute_done=1 -> SHOW.
- SHOW: show_result=1. On press_evt -> CLEAR; the restarting press is not counted as an entry.
- press_evt arriving in any state other than WAIT_ENTRY or SHOW is dropped, never queued.
- Simultaneous events:
  - compute_done and press_evt in the same cycle in WAIT_DONE -> SHOW; the press is dropped.
  - inputdata_ready already high on entry to WAIT_ACK: WAIT_ACK is left after one cycle.
- entry_count never exceeds NUM_ENTRIES and does not wrap.
- Reset mid-operation returns to CLEAR at once; an in-flight strobe is cut.
- Without ENTRY_TIMEOUT_EN, err_timeout is tied to 0.

Optional Feature:
Macro ENTRY_TIMEOUT_EN.
- Defined: an idle counter runs in WAIT_ENTRY while entry_count>0 and is cleared by press_evt or on leaving WAIT_ENTRY. When it reaches TIMEOUT_CYCLES, the FSM goes to CLEAR, err_timeout sets, and partial entries are discarded. err_timeout clears on the next press_evt accepted in WAIT_ENTRY, or on reset.
- Undefined: no counter; WAIT_ENTRY waits indefinitely; err_timeout=0.

Decomposition:
- Package seq_pkg holds:
  - state enum state_t with the fixed encodings above;
  - SYNC_STAGES=2;
  - the entry_count width constant CNT_W=4.
- One sub-module, button_debouncer (synchronizer + debounce + press_evt), parameterized by DEBOUNCE_CYCLES.
- The FSM, counters and optional timeout live in entry_sequencer.

Test Plan:
1. Reset, then hold nenter=0 for 20 cycles -> one loaddata pulse at cycle 7 after the fall; entry_count=1; no repeat while held.
2. 3-cycle low glitch on nenter -> no loaddata; state_code stays 1.
3. 4 full presses, datapath acks inputdata_ready 2 cycles after each loaddata -> 4 loaddata pulses, entry_count 1..4, one compute_start after the 4th ack; compute_done 5 cycles later -> show_result=1, state_code=6.
4. Press during WAIT_DONE, then press in SHOW -> first press dropped; second gives clear_acc pulse, entry_count=0, state_code=1.
5. nreset low while in WAIT_ACK with entry_count=2 -> all outputs 0 and state_code=0 immediately; after release, clear_acc pulses once.
6. (ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=64) one press, then idle 64 cycles -> state CLEAR, err_timeout=1, entry_count=0; next press -> err_timeout=0 and entry_count=1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the entry sequencer.
// Optional build macro ENTRY_TIMEOUT_EN enables the idle entry timeout.
package seq_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_CLEAR      = 3'd0,
    ST_WAIT_ENTRY = 3'd1,
    ST_LOAD       = 3'd2,
    ST_WAIT_ACK   = 3'd3,
    ST_COMPUTE    = 3'd4,
    ST_WAIT_DONE  = 3'd5,
    ST_SHOW       = 3'd6
  } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces the active-low enter button.
// press_evt pulses once per debounced released->pressed transition.
module button_debouncer
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic nenter,
  output logic press_evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          cnt;
  logic                   level;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];

  // Metastability chain; resets to the released level.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], nenter};
    end
  end

  // Level flips after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      level     <= 1'b1;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        level     <= sample;
        cnt       <= '0;
        press_evt <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entry_sequencer.sv
// Entry/accumulate/display control FSM driven by the enter button.
// Optional build macro ENTRY_TIMEOUT_EN enables the idle entry timeout.
module entry_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_ENTRIES     = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             nenter,
  input  logic             inputdata_ready,
  input  logic             compute_done,
  output logic             loaddata,
  output logic             clear_acc,
  output logic             compute_start,
  output logic             show_result,
  output logic [CNT_W-1:0] entry_count,
  output logic [2:0]       state_code,
  output logic             err_timeout
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             press_evt;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .nreset   (nreset),
    .nenter   (nenter),
    .press_evt(press_evt)
  );

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle;
  logic [TW-1:0] idle_n;
  logic          err;
  logic          err_n;
  logic          timeout;

  assign timeout     = (idle == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err;

  // Idle counter and sticky timeout flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idle <= '0;
      err  <= 1'b0;
    end else begin
      idle <= idle_n;
      err  <= err_n;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  // State and accepted-entry count registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= ST_CLEAR;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // Next-state logic; presses outside WAIT_ENTRY/SHOW are dropped.
  always_comb begin
    state_n = state;
    count_n = count;
`ifdef ENTRY_TIMEOUT_EN
    idle_n  = '0;
    err_n   = err;
`endif
    unique case (state)
      ST_CLEAR: begin
        count_n = '0;
        state_n = ST_WAIT_ENTRY;
      end
      ST_WAIT_ENTRY: begin
        if (press_evt) begin
          state_n = ST_LOAD;
`ifdef ENTRY_TIMEOUT_EN
          err_n   = 1'b0;
        end else if (count != '0) begin
          if (timeout) begin
            state_n = ST_CLEAR;
            err_n   = 1'b1;
          end else begin
            idle_n = idle + 1'b1;
          end
`endif
        end
      end
      ST_LOAD: begin
        if (count < CNT_W'(NUM_ENTRIES)) begin
          count_n = count + 1'b1;
        end
        state_n = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (inputdata_ready) begin
          state_n = (count == CNT_W'(NUM_ENTRIES)) ?
                    ST_COMPUTE : ST_WAIT_ENTRY;
        end
      end
      ST_COMPUTE: begin
        state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (compute_done) begin
          state_n = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (press_evt) begin
          state_n = ST_CLEAR;
        end
      end
      default: begin
        state_n = ST_CLEAR;
      end
    endcase
  end

  // Strobes are gated by reset so nothing fires while held in reset.
  assign loaddata      = nreset && (state == ST_LOAD);
  assign clear_acc     = nreset && (state == ST_CLEAR);
  assign compute_start = nreset && (state == ST_COMPUTE);
  assign show_result   = nreset && (state == ST_SHOW);
  assign entry_count   = count;
  assign state_code    = state;

endmodule

// File: tb/tb_entry_sequencer.sv
// Scoreboard bench for entry_sequencer with random press/ack timing.
// Define ENTRY_TIMEOUT_EN to also exercise the idle timeout.
module tb_entry_sequencer;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int TO    = 64;
  localparam int HOLD2 = 8;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic       nenter = 1'b1;
  logic       inputdata_ready = 1'b0;
  logic       compute_done = 1'b0;
  logic       loaddata;
  logic       clear_acc;
  logic       compute_start;
  logic       show_result;
  logic [3:0] entry_count;
  logic [2:0] state_code;
  logic       err_timeout;

  entry_sequencer #(
    .NUM_ENTRIES    (N),
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .nenter         (nenter),
    .inputdata_ready(inputdata_ready),
    .compute_done   (compute_done),
    .loaddata       (loaddata),
    .clear_acc      (clear_acc),
    .compute_start  (compute_start),
    .show_result    (show_result),
    .entry_count    (entry_count),
    .state_code     (state_code),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef enum int {EV_CLEAR, EV_LOAD, EV_COMP, EV_SHOW} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       at;
    int       cnt;
    bit       err;
  } ev_t;

  ev_t sb[$];
  int  model_entries = 0;
  bit  model_err = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int code_of(input ev_kind_t k);
    case (k)
      EV_CLEAR: return 0;
      EV_LOAD:  return 2;
      EV_COMP:  return 4;
      default:  return 6;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input int at,
                           input int cnt);
    ev_t e;
    e.kind = k;
    e.at   = at;
    e.cnt  = cnt;
    e.err  = model_err;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  bit    pend = 1'b0;
  int    pend_cnt;
  string pend_nm;
  logic  p_load = 1'b0;
  logic  p_clear = 1'b0;
  logic  p_comp = 1'b0;
  logic  p_show = 1'b0;

  task automatic got(input ev_kind_t k, input string nm);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s at cycle %0d: got event, expected none",
               nm, cyc);
    end else begin
      e = sb.pop_front();
      check({nm, " kind"}, int'(k), int'(e.kind));
      check({nm, " cycle"}, cyc, e.at);
      check({nm, " state_code"}, int'(state_code), code_of(k));
      check({nm, " err_timeout"}, int'(err_timeout), int'(e.err));
      pend     = 1'b1;
      pend_cnt = e.cnt;
      pend_nm  = nm;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (pend) begin
          check({pend_nm, " entry_count after"}, int'(entry_count),
                pend_cnt);
          pend = 1'b0;
        end
        if (loaddata) check("loaddata one-cycle", int'(p_load), 0);
        if (clear_acc) check("clear_acc one-cycle", int'(p_clear), 0);
        if (compute_start) check("compute_start one-cycle", int'(p_comp), 0);
        if (clear_acc && !p_clear) got(EV_CLEAR, "clear_acc");
        if (loaddata && !p_load) got(EV_LOAD, "loaddata");
        if (compute_start && !p_comp) got(EV_COMP, "compute_start");
        if (show_result && !p_show) got(EV_SHOW, "show_result");
        p_load  = loaddata;
        p_clear = clear_acc;
        p_comp  = compute_start;
        p_show  = show_result;
      end else begin
        pend    = 1'b0;
        p_load  = 1'b0;
        p_clear = 1'b0;
        p_comp  = 1'b0;
        p_show  = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("reset strobes",
          int'({loaddata, clear_acc, compute_start, show_result}), 0);
    check("reset state_code", int'(state_code), 0);
    check("reset entry_count", int'(entry_count), 0);
    check("reset err_timeout", int'(err_timeout), 0);
    nenter = 1'b1;
    inputdata_ready = 1'b0;
    compute_done = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    model_entries = 0;
    model_err = 1'b0;
    expect_ev(EV_CLEAR, cyc, 0);
  endtask

  // A press from WAIT_ENTRY; datapath acks at t=tr, finishes at t=td.
  // mode 1: extra press dropped in WAIT_DONE; mode 2: with compute_done.
  task automatic press_entry(input int hold, input int ack_d,
                             input bit early, input int mode_in,
                             input bit ack_en, output int idle_from);
    int c0, tr, t2, td, len, mode;
    bit last;
    tr = 8 + ack_d;
    @(negedge clk);
    c0 = cyc;
    model_entries++;
    model_err = 1'b0;
    last = (model_entries == N);
    mode = (last && ack_en) ? mode_in : 0;
    t2 = imax(tr + 2, hold + D + 4);
    td = -10;
    expect_ev(EV_LOAD, c0 + 7, model_entries);
    if (last && ack_en) begin
      expect_ev(EV_COMP, c0 + tr + 1, N);
      if (mode == 0) td = tr + 2 + $urandom_range(0, 5);
      else if (mode == 1) td = t2 + HOLD2 + D + 4 + $urandom_range(0, 3);
      else td = t2 + 6;
      expect_ev(EV_SHOW, c0 + td + 1, N);
    end
    idle_from = c0 + tr + 1;
    len = imax(hold + D + 6, imax(tr + 2, td + 2));
    if (mode != 0) len = imax(len, t2 + HOLD2 + D + 6);
    for (int t = 0; t < len; t++) begin
      if (t > 0) @(negedge clk);
      nenter = !((t < hold) ||
                 (mode != 0 && t >= t2 && t < t2 + HOLD2));
      inputdata_ready = ack_en && (t == tr || (early && t == 7));
      compute_done = last && ack_en && (t == td);
    end
    @(negedge clk);
    nenter = 1'b1;
    inputdata_ready = 1'b0;
    compute_done = 1'b0;
  endtask

  task automatic press_restart(input int hold);
    @(negedge clk);
    model_entries = 0;
    expect_ev(EV_CLEAR, cyc + 7, 0);
    for (int t = 0; t < hold + D + 6; t++) begin
      if (t > 0) @(negedge clk);
      nenter = !(t < hold);
    end
  endtask

  task automatic glitch(input int len, input int exp_state);
    for (int t = 0; t < len + D + 6; t++) begin
      @(negedge clk);
      nenter = !(t < len);
    end
    check("state after glitch", int'(state_code), exp_state);
  endtask

  initial begin
    #(400000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idle_from;
    int hold;
    #1;
    nreset = 1'b0;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int e = 1; e <= N; e++) begin
        if ($urandom_range(0, 1) == 1) glitch($urandom_range(1, D - 1), 1);
        hold = (r == 0 && e == 1) ? 20 : $urandom_range(D + 1, 16);
        press_entry(hold, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    r % 3, 1'b1, idle_from);
      end
      glitch(D - 1, 6);
      press_restart($urandom_range(D + 1, 16));
    end

    press_entry(10, 1, 1'b0, 0, 1'b1, idle_from);
    press_entry(10, 0, 1'b0, 0, 1'b0, idle_from);
    check("mid entry_count", int'(entry_count), 2);
    check("mid state_code", int'(state_code), 3);
    do_reset();

`ifdef ENTRY_TIMEOUT_EN
    press_entry(10, 2, 1'b0, 0, 1'b1, idle_from);
    model_entries = 0;
    model_err = 1'b1;
    expect_ev(EV_CLEAR, idle_from + TO, 0);
    while (cyc < idle_from + TO + 4) @(negedge clk);
    check("timeout err_timeout", int'(err_timeout), 1);
    check("timeout entry_count", int'(entry_count), 0);
    press_entry(10, 1, 1'b0, 0, 1'b1, idle_from);
    check("after timeout err_timeout", int'(err_timeout), 0);
    check("after timeout entry_count", int'(entry_count), 1);
`endif

    repeat (20) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
